// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NUM_VOICES voices with age-based retrigger/steal.
// Optional VOICE_ALLOCATOR_STEAL_EN: steal the oldest voice when all are busy (else drop the note-on).
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_BITS  = 7,
    parameter int VEL_BITS   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic [VEL_BITS-1:0]             ev_vel,
    input  logic [NUM_VOICES-1:0]           voice_avail,
    output logic [NUM_VOICES-1:0]           voice_en,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic [NUM_VOICES*VEL_BITS-1:0]  voice_vel,
    output logic                            drop,
    output logic [4:0]                      busy_cnt
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [IW-1:0] AGE_MAX = IW'(NUM_VOICES - 1);

`ifdef VOICE_ALLOCATOR_STEAL_EN
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT, S_RETRIG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} state_t;
`endif
    typedef enum logic [2:0] {K_IGNORE, K_ON, K_OFF, K_STEAL, K_DROP} kind_t;

    state_t                 state_q;
    kind_t                  kind_q, srch_kind;
    logic                   ev_ready_q, drop_q, on_q;
    logic [NOTE_BITS-1:0]   note_q;
    logic [VEL_BITS-1:0]    vel_q;
    logic [IW-1:0]          tgt_q, srch_tgt;

    logic [NUM_VOICES-1:0]                busy_q, busy_d, en_q, en_d;
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] vnote_q, vnote_d;
    logic [NUM_VOICES-1:0][VEL_BITS-1:0]  vvel_q, vvel_d;
    logic [NUM_VOICES-1:0][IW-1:0]        age_q, age_d;
    logic [4:0]                           busy_cnt_q, busy_cnt_d;

    logic          match_found, free_found;
    logic [IW-1:0] match_idx, free_idx, old_idx, old_age, prior_age;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!match_found && en_q[i] && vnote_q[i] == note_q) begin
                match_found = 1'b1;
                match_idx   = IW'(i);
            end
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            // oldest voice; strict compare keeps the lowest index on ties
            if (i == 0 || age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IW'(i);
            end
        end
    end

    always_comb begin
        srch_kind = K_IGNORE;
        srch_tgt  = match_idx;
        if (on_q) begin
            if (match_found) begin
                srch_kind = K_ON;
            end else if (free_found) begin
                srch_kind = K_ON;
                srch_tgt  = free_idx;
            end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                srch_kind = K_STEAL;
                srch_tgt  = old_idx;
`else
                srch_kind = K_DROP;
`endif
            end
        end else if (match_found) begin
            srch_kind = K_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ev_ready_q <= 1'b1;
            on_q       <= 1'b0;
            note_q     <= '0;
            vel_q      <= '0;
            tgt_q      <= '0;
            kind_q     <= K_IGNORE;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                S_IDLE: if (ev_valid && ev_ready_q) begin
                    on_q       <= ev_on;
                    note_q     <= ev_note;
                    vel_q      <= ev_vel;
                    ev_ready_q <= 1'b0;
                    state_q    <= S_SEARCH;
                end
                S_SEARCH: begin
                    kind_q  <= srch_kind;
                    tgt_q   <= srch_tgt;
                    drop_q  <= (srch_kind == K_DROP);
                    state_q <= S_COMMIT;
                end
                S_COMMIT: begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    if (kind_q == K_STEAL) begin
                        state_q <= S_RETRIG;
                    end else begin
                        state_q    <= S_IDLE;
                        ev_ready_q <= 1'b1;
                    end
`else
                    state_q    <= S_IDLE;
                    ev_ready_q <= 1'b1;
`endif
                end
                default: begin
                    state_q    <= S_IDLE;
                    ev_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        busy_d    = busy_q;
        en_d      = en_q;
        vnote_d   = vnote_q;
        vvel_d    = vvel_q;
        age_d     = age_q;
        prior_age = busy_q[tgt_q] ? age_q[tgt_q] : AGE_MAX;
        for (int i = 0; i < NUM_VOICES; i++)
            if (voice_avail[i] && !en_q[i]) busy_d[i] = 1'b0;
        // commit writes come after the release so a same-cycle commit keeps the voice busy
        if (state_q == S_COMMIT) begin
            if (kind_q == K_ON || kind_q == K_STEAL) begin
                for (int j = 0; j < NUM_VOICES; j++)
                    if (busy_q[j] && IW'(j) != tgt_q && age_q[j] < prior_age)
                        age_d[j] = age_q[j] + 1'b1;
                age_d[tgt_q]   = '0;
                busy_d[tgt_q]  = 1'b1;
                en_d[tgt_q]    = (kind_q == K_ON);
                vnote_d[tgt_q] = note_q;
                vvel_d[tgt_q]  = vel_q;
            end else if (kind_q == K_OFF) begin
                en_d[tgt_q] = 1'b0;
            end
        end
`ifdef VOICE_ALLOCATOR_STEAL_EN
        if (state_q == S_RETRIG) begin
            en_d[tgt_q]   = 1'b1;
            busy_d[tgt_q] = 1'b1;
        end
`endif
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            busy_cnt_d = busy_cnt_d + 5'(busy_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            en_q       <= '0;
            vnote_q    <= '0;
            vvel_q     <= '0;
            age_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            en_q       <= en_d;
            vnote_q    <= vnote_d;
            vvel_q     <= vvel_d;
            age_q      <= age_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign ev_ready   = ev_ready_q;
    assign drop       = drop_q;
    assign busy_cnt   = busy_cnt_q;
    assign voice_en   = en_q;
    assign voice_note = vnote_q;
    assign voice_vel  = vvel_q;
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 8: number of envelope/oscillator voices managed; 2..16.
REQ-002 Parameter NOTE_BITS, default 7: MIDI note number width.
REQ-003 Parameter VEL_BITS, default 32: per-voice velocity/level word, {attack[15:0], decay[15:0]}.
REQ-004 Clock and reset: clk, rising edge; rst, synchronous, active-high.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ev_valid  in  1  note event present
- ev_ready  out  1  event accepted when ev_valid && ev_ready
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_BITS  note number
- ev_vel  in  VEL_BITS  velocity word; ignored for note-off
- voice_avail  in  NUM_VOICES  per-voice one-cycle pulse from envelope: decayed to idle
- voice_en  out  NUM_VOICES  per-voice gate; high = key held (attack/sustain), low = release
- voice_note  out  NUM_VOICES*NOTE_BITS  packed note per voice; voice i at [i*NOTE_BITS +: NOTE_BITS]
- voice_vel  out  NUM_VOICES*VEL_BITS  packed velocity per voice; same packing
- drop  out  1  one-cycle pulse: note-on discarded
- busy_cnt  out  5  number of busy voices

Function
REQ-006 Per-voice state:
- busy[i]: set on allocation; cleared when voice_avail[i]=1 and voice_en[i]=0.
- age[i]: clog2(NUM_VOICES) bits; 0 = newest.
REQ-007 FSM S_IDLE -> S_SEARCH -> S_COMMIT -> S_IDLE; S_RETRIG between S_COMMIT and S_IDLE for steals only.
REQ-008 ev_ready=1 only in S_IDLE. Accept latches ev_on, ev_note and ev_vel, then enters S_SEARCH.
REQ-009 S_SEARCH note-on, first match wins:
- (a) a voice with voice_en=1 and matching note: retrigger that voice.
- (b) else the lowest-index voice with busy=0.
- (c) else steal or drop per REQ-020.
REQ-010 S_SEARCH note-off: target the lowest-index voice with voice_en=1 and matching note. No match: event ignored, no outputs change.
REQ-011 S_COMMIT note-on:
- target voice_note and voice_vel updated; voice_en=1; busy=1.
- registered outputs are visible 2 cycles after the accept edge.
- return to S_IDLE.
REQ-012 S_COMMIT note-off: target voice_en=0; voice_note and voice_vel held; busy stays 1 until voice_avail.
REQ-013 Age update on every allocation or retrigger:
- target age := 0.
- every busy voice whose age is below the target's prior age increments.
- a previously free target counts as prior age NUM_VOICES-1.
- ages never exceed NUM_VOICES-1.
REQ-014 voice_avail[i] arriving in the same cycle as a commit to voice i: the commit wins and busy[i] stays 1.
REQ-015 voice_avail[i] while voice_en[i]=1: ignored.
REQ-016 busy_cnt = popcount(busy), registered, updated one cycle after any busy change.
REQ-017 Events arriving with ev_ready=0 are not consumed. The upstream holds ev_valid and the event.

Reset
REQ-018 Reset state:
- FSM to S_IDLE.
- busy, voice_en, voice_note, voice_vel, age, busy_cnt and drop all 0.
- ev_ready=1 from the first cycle after reset.
REQ-019 Reset asserted mid-event aborts the event with no voice change. Reset dominates voice_avail.

Configuration
REQ-020 Macro VOICE_ALLOCATOR_STEAL_EN.
- Defined: a note-on with all voices busy steals the voice with age NUM_VOICES-1:
  - S_COMMIT drives its voice_en=0 for exactly one cycle, with new note and velocity loaded.
  - S_RETRIG drives voice_en=1.
  - ages update per REQ-013.
  - drop is never asserted.
- Undefined: a note-on with all voices busy is discarded, with drop=1 for one cycle in S_COMMIT and no voice state change. S_RETRIG is not present.

Verification
REQ-021 Reset, then note-on note=60 vel=0x8000_4000 -> voice_en=0x01 two cycles after accept, voice_note[0]=60, voice_vel[0]=0x80004000, busy_cnt=1.
REQ-022 Note-on 60, 62, 64, then note-off 62, then voice_avail[1] pulse -> voice_en 0x07 -> 0x05; busy_cnt 3 -> 2 one cycle after the pulse; next note-on 65 lands in voice 1.
REQ-023 Fill all 8 voices with notes 40..47 and issue note-on 50:
- STEAL_EN defined: voice 0 voice_en goes 1,0,1 on consecutive cycles with voice_note[0]=50, drop=0.
- STEAL_EN undefined: drop pulses once, all voice state unchanged.
REQ-024 Note-on 60 twice with vel A, then B -> same voice 0, voice_en held high, voice_vel[0]=B, busy_cnt=1. Note-off 61 -> no change.
REQ-025 Note-off 60 on voice 0, then voice_avail[0] and a new note-on committing to voice 0 in the same cycle -> busy[0]=1, voice_en[0]=1.
REQ-026 rst asserted during S_SEARCH -> next cycle all outputs 0, ev_ready=1, no voice_en glitch.
